// File: rtl/l1_dcache_dm.sv
// Direct-mapped, write-back, write-allocate L1 data cache with 32-byte lines.
// Word-granular core port upstream, 256-bit line port to physical memory.
module l1_dcache_dm #(
    parameter int S_INDEX = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [3:0]   mem_byte_enable,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);
    localparam int S_OFFSET = 5;
    localparam int LINES    = 2 ** S_INDEX;
    localparam int TAG_W    = 32 - S_INDEX - S_OFFSET;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t state, state_next;

    logic [LINES-1:0] valid_bits;
    logic [LINES-1:0] dirty_bits;
    logic [TAG_W-1:0] tag_arr  [LINES];
    logic [255:0]     data_arr [LINES];

    logic [TAG_W-1:0]   req_tag;
    logic [S_INDEX-1:0] req_idx;
    logic [2:0]         req_word;
    logic [7:0]         word_base;
    logic               req_any;
    logic               hit;
    logic [31:0]        cur_word;
    logic [31:0]        merged_word;

    // Miss bookkeeping is latched so pmem_address stays stable even if the core
    // drops or changes its request while a line transfer is in progress.
    logic [TAG_W-1:0]   miss_tag;
    logic [S_INDEX-1:0] miss_idx;

    logic fill_en;
    logic write_hit;
    logic capture_miss;

    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_address[1:0];

    assign req_tag   = mem_address[31 -: TAG_W];
    assign req_idx   = mem_address[S_INDEX+S_OFFSET-1:S_OFFSET];
    assign req_word  = mem_address[4:2];
    assign word_base = {req_word, 5'b0};
    assign req_any   = mem_read | mem_write;
    assign hit       = valid_bits[req_idx] && (tag_arr[req_idx] == req_tag);
    assign cur_word  = data_arr[req_idx][word_base +: 32];

    // Byte-lane merge of the core write data into the currently stored word.
    always_comb begin
        merged_word = cur_word;
        for (int b = 0; b < 4; b++) begin
            if (mem_byte_enable[b]) merged_word[8*b +: 8] = mem_wdata[8*b +: 8];
        end
    end

    // FSM next-state and all port outputs; everything defaults to 0.
    always_comb begin
        state_next   = state;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        fill_en      = 1'b0;
        write_hit    = 1'b0;
        capture_miss = 1'b0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    if (hit) begin
                        mem_resp  = 1'b1;
                        mem_rdata = cur_word;
                        write_hit = mem_write;
                    end else begin
                        capture_miss = 1'b1;
                        if (valid_bits[req_idx] && dirty_bits[req_idx]) state_next = WRITEBACK;
                        else                                            state_next = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_arr[miss_idx], miss_idx, 5'b0};
                pmem_wdata   = data_arr[miss_idx];
                if (pmem_resp) state_next = ALLOCATE;
            end
            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {miss_tag, miss_idx, 5'b0};
                if (pmem_resp) begin
                    fill_en    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Valid/dirty bits; reset discards every line including dirty ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (fill_en) begin
            valid_bits[miss_idx] <= 1'b1;
            dirty_bits[miss_idx] <= 1'b0;
        end else if (write_hit) begin
            dirty_bits[req_idx] <= 1'b1;
        end
    end

    // Tag and data arrays: line fills and write-hit word merges, never reset.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_arr[miss_idx]  <= miss_tag;
            data_arr[miss_idx] <= pmem_rdata;
        end else if (write_hit) begin
            data_arr[req_idx][word_base +: 32] <= merged_word;
        end
    end

    // Capture the missing line's tag/index when leaving IDLE.
    always_ff @(posedge clk) begin
        if (capture_miss) begin
            miss_tag <= req_tag;
            miss_idx <= req_idx;
        end
    end
endmodule
